serial_sub: RTL and testbench

- Bit-serial subtractor computing A − B one bit per clock, LSB first, using a full-subtractor cell and a registered borrow.
- Companion to the full-adder cell in the MAC datapath.
- Provides the subtract direction for weight-update and error (target − output) terms, at minimal area.
- Word-parallel load/unload with a start/busy/done handshake.

---
 rtl/serial_sub.sv | 127 ++++++++++++
 tb/tb_serial_sub.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a
// single full-subtractor cell and a registered borrow. Operands are loaded
// word-parallel on an accepted start; the result is unloaded word-parallel
// on a one-cycle done pulse and held until the next result is ready.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over everything)
//   start      request a new subtraction (accepted in IDLE or DONE only)
//   a, b       minuend / subtrahend, sampled on the accepting edge only
//   busy       high while bits are being processed
//   done       one-cycle pulse, result outputs valid
//   diff       (a - b) mod 2^WIDTH
//   borrow_out final borrow, i.e. unsigned a < b
//   ovf        signed two's-complement overflow
//   zero       diff == 0
// ---------------------------------------------------------------------------
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  assign d_bit    = sa[0] ^ sb[0] ^ br;
  assign br_next  = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
  // Result fills from the top so that after WIDTH shifts bit 0 sits at LSB.
  assign res_next = {d_bit, res[WIDTH-1:1]};

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, as the hardware does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE behaves like IDLE for acceptance, giving back-to-back issue.
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            br    <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          // start is deliberately not looked at here.
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          res <= res_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            diff       <= res_next;
            borrow_out <= br_next;
            // Overflow only when operand signs differ and the result sign
            // disagrees with the minuend's.
            ovf        <= (a_msb != b_msb) & (res_next[WIDTH-1] != a_msb);
            zero       <= (res_next == '0);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub
// Directed bench for serial_sub at WIDTH=8 and WIDTH=16. Expected results
// come from a small arithmetic model inside the bench.
// ---------------------------------------------------------------------------
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel16 = 1'b0;
  logic [31:0] a_v = '0;
  logic [31:0] b_v = '0;

  logic        busy8, done8, bo8, ovf8, zero8;
  logic [7:0]  diff8;
  logic        busy16, done16, bo16, ovf16, zero16;
  logic [15:0] diff16;

  logic        start8, start16;
  assign start8  = start & ~sel16;
  assign start16 = start & sel16;

  // Outputs of whichever DUT is selected.
  logic        busy_m, done_m, bo_m, ovf_m, zero_m;
  logic [31:0] diff_m;
  assign busy_m = sel16 ? busy16 : busy8;
  assign done_m = sel16 ? done16 : done8;
  assign bo_m   = sel16 ? bo16   : bo8;
  assign ovf_m  = sel16 ? ovf16  : ovf8;
  assign zero_m = sel16 ? zero16 : zero8;
  assign diff_m = sel16 ? {16'h0, diff16} : {24'h0, diff8};

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a_v[7:0]), .b(b_v[7:0]),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8),
    .ovf(ovf8), .zero(zero8)
  );

  serial_sub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a_v[15:0]), .b(b_v[15:0]),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16),
    .ovf(ovf16), .zero(zero16)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Last result each DUT should be holding: {diff} and {borrow, ovf, zero}.
  logic [31:0] prev_diff  [2];
  logic [2:0]  prev_flags [2];

  // Run one operation on the selected DUT. glitch_at >= 0 pulses start with
  // a=0x10, b=0x01 for one cycle that many cycles into RUN.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       input int glitch_at, input string tag);
    int          w;
    logic [31:0] mask;
    logic [31:0] exp_diff;
    logic        exp_bo, exp_ovf, exp_zero, am, bm;
    int          cycles;
    int          busy_cnt;
    int          idx;
    w    = sel16 ? 16 : 8;
    mask = sel16 ? 32'hFFFF : 32'hFF;
    idx  = sel16 ? 1 : 0;
    av   = av & mask;
    bv   = bv & mask;
    exp_diff = (av - bv) & mask;
    exp_bo   = (av < bv);
    exp_zero = (exp_diff == 0);
    am       = av[w-1];
    bm       = bv[w-1];
    exp_ovf  = (am != bm) && (exp_diff[w-1] != am);

    @(negedge clk);
    a_v   = av;
    b_v   = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_v   = $urandom;
    b_v   = $urandom;

    cycles   = 0;
    busy_cnt = 0;
    while (done_m !== 1'b1 && cycles < 4 * w) begin
      if (busy_m === 1'b1) busy_cnt++;
      checks++;
      if (diff_m !== prev_diff[idx] || {bo_m, ovf_m, zero_m} !== prev_flags[idx]) begin
        errors++;
        $display("FAIL %s hold: diff=%h flags=%b, required diff=%h flags=%b",
                 tag, diff_m, {bo_m, ovf_m, zero_m}, prev_diff[idx], prev_flags[idx]);
      end
      if (cycles == glitch_at) begin
        start = 1'b1;
        a_v   = 32'h10;
        b_v   = 32'h01;
      end
      @(posedge clk); #1;
      if (cycles == glitch_at) start = 1'b0;
      cycles++;
    end
    start = 1'b0;

    checks++;
    if (cycles !== w) begin
      errors++;
      $display("FAIL %s latency: %0d cycles, required %0d", tag, cycles, w);
    end
    checks++;
    if (busy_cnt !== w || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: high %0d cycles, busy at done=%b, required %0d and 0",
               tag, busy_cnt, busy_m, w);
    end
    checks++;
    if (diff_m !== exp_diff) begin
      errors++;
      $display("FAIL %s diff: got %h, required %h", tag, diff_m, exp_diff);
    end
    checks++;
    if ({bo_m, ovf_m, zero_m} !== {exp_bo, exp_ovf, exp_zero}) begin
      errors++;
      $display("FAIL %s flags(borrow,ovf,zero): got %b, required %b",
               tag, {bo_m, ovf_m, zero_m}, {exp_bo, exp_ovf, exp_zero});
    end
    prev_diff[idx]  = exp_diff;
    prev_flags[idx] = {exp_bo, exp_ovf, exp_zero};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, diff8, bo8, ovf8, zero8} !== 13'h0 ||
        {busy16, done16, diff16, bo16, ovf16, zero16} !== 21'h0) begin
      errors++;
      $display("FAIL reset_state: dut8=%b dut16=%b, required all zero",
               {busy8, done8, diff8, bo8, ovf8, zero8},
               {busy16, done16, diff16, bo16, ovf16, zero16});
    end
    rst = 1'b0;
    prev_diff[0] = '0; prev_diff[1] = '0;
    prev_flags[0] = '0; prev_flags[1] = '0;
  endtask

  task automatic test_basic();
    sel16 = 1'b0;
    do_op(32'h05, 32'h03, -1, "sub_05_03");
    // Let it drop back to IDLE and confirm done was a single pulse.
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b, required 0 0", done8, busy8);
    end
    do_op(32'h03, 32'h05, -1, "sub_03_05");
    do_op(32'h2A, 32'h2A, -1, "sub_2A_2A");
    do_op(32'h80, 32'h01, -1, "sub_80_01");
    do_op(32'h7F, 32'hFF, -1, "sub_7F_FF");
    do_op(32'h00, 32'h01, -1, "sub_00_01");
    do_op(32'hFF, 32'h00, -1, "sub_FF_00");
  endtask

  task automatic test_busy_start();
    sel16 = 1'b0;
    do_op(32'h05, 32'h03, 3, "ignored_start");
  endtask

  // do_op leaves the bench in the DONE cycle, so the next call issues in it.
  task automatic test_back_to_back();
    sel16 = 1'b0;
    do_op(32'h05, 32'h03, -1, "b2b_first");
    do_op(32'h10, 32'h01, -1, "b2b_second");
  endtask

  task automatic test_mid_run_reset();
    int saw_done;
    sel16 = 1'b0;
    @(negedge clk);
    a_v = 32'h05; b_v = 32'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy8, done8, diff8, bo8, ovf8, zero8} !== 13'h0) begin
      errors++;
      $display("FAIL mid_run_reset: outputs=%b, required all zero",
               {busy8, done8, diff8, bo8, ovf8, zero8});
    end
    prev_diff[0] = '0; prev_diff[1] = '0;
    prev_flags[0] = '0; prev_flags[1] = '0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done != 0) begin
      errors++;
      $display("FAIL reset_discard: done/busy seen after reset=%0d, required 0", saw_done);
    end
    do_op(32'h09, 32'h04, -1, "after_reset");
  endtask

  task automatic test_wide();
    sel16 = 1'b1;
    do_op(32'h8000, 32'h0001, -1, "w16_8000_0001");
    do_op(32'h1234, 32'h4321, -1, "w16_1234_4321");
    do_op(32'hFFFF, 32'hFFFF, -1, "w16_FFFF_FFFF");
    sel16 = 1'b0;
  endtask

  task automatic test_random();
    for (int w = 0; w < 2; w++) begin
      sel16 = (w == 1);
      for (int i = 0; i < 150; i++)
        do_op($urandom, $urandom, -1, w == 1 ? "rand16" : "rand8");
    end
    sel16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_start();
    test_back_to_back();
    test_mid_run_reset();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
